start_pulse_frame_tx: RTL and testbench
=======================================

// Module: start_pulse_frame_tx
// PURPOSE
//  Transmit side of the start-pulse serial link. Accepts a data word over a
//  valid/ready handshake and emits one frame on data_out: a high preamble, a
//  falling edge into a low start pulse, then DATA_WIDTH bits MSB-first, then a
//  low guard. The falling edge after the preamble is what the receive-side
//  start pulse detector keys on. Sits between the controller core and the pad.
// PARAMETERS
//  DATA_WIDTH   8   bits per frame payload (>=1)
//  PRE_TICKS    4   clocks data_out held high before the start pulse (>=1)
//  START_TICKS  4   clocks of the low start pulse (>=1)
//  BIT_TICKS    8   clocks per payload bit (>=1)
//  GUARD_TICKS  4   clocks data_out held low after the last bit (>=1)
// PORTS
//  clock     in   1           rising-edge clock
//  reset     in   1           synchronous, active-high reset
//  tx_valid  in   1           tx_data is valid this cycle
//  tx_data   in   DATA_WIDTH  payload, sampled on accept
//  tx_ready  out  1           block can accept a word this cycle
//  data_out  out  1           serial line, registered
//  busy      out  1           frame in progress (any state but IDLE)
//  done      out  1           one-cycle pulse on the last GUARD cycle
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, data_out=0, tx_ready=1, busy=0, done=0,
//    shift reg=0, tick/bit counters=0. Reset mid-frame aborts it on the next
//    edge; data_out=0 the cycle after reset is sampled high. No partial resume.
//  - Accept: tx_valid & tx_ready at a rising edge latches tx_data into the
//    shift reg and enters PRE. tx_ready = (state==IDLE) & ~reset (combinational).
//    tx_valid while busy is ignored; no queueing.
//  - FSM (all outputs registered; tick counter counts 0..N-1, then advances):
//    IDLE : data_out=0; on accept -> PRE.
//    PRE  : data_out=1 for PRE_TICKS clocks -> START.
//    START: data_out=0 for START_TICKS clocks -> DATA.
//    DATA : data_out=shift[DATA_WIDTH-1] for BIT_TICKS clocks per bit; shift
//           left by 1 at each bit boundary; after DATA_WIDTH bits -> GUARD.
//    GUARD: data_out=0 for GUARD_TICKS clocks; done=1 on its final cycle
//           -> IDLE.
//    Illegal state encodings go to IDLE.
//  - Latency: data_out rises on the first cycle after the accept edge. Frame
//    length = PRE+START+DATA_WIDTH*BIT_TICKS+GUARD clocks. tx_ready is high
//    again on the cycle after done. Back-to-back: an accept on that cycle
//    starts PRE with no extra idle.
//  - Counters: tick counter width clog2(max tick param)+1; bit counter width
//    clog2(DATA_WIDTH)+1; no wrap within a state. Both clear on state change.
//  - Bit value 1 followed by 0 in DATA gives a legal falling edge. The link
//    layer, not this block, gates the receiver's detector during payload.
// STRUCTURE
//  - Package start_pulse_pkg: state encodings (IDLE, PRE, START, DATA,
//    GUARD, 3-bit) and default tick constants shared with the receive side.
//  - Sub-module start_pulse_tick_timer: loadable down-counter with a
//    terminal-count flag. Reloaded on each state or bit boundary with the
//    relevant *_TICKS-1.
//  - Top: FSM, shift register, bit counter, output registers.
// TESTING (defaults unless stated)
//  - Reset: hold reset 3 cycles -> data_out=0, tx_ready=1, busy=0, done=0.
//  - Single frame 8'hA5 -> 4 clk high, 4 clk low, bits 1,0,1,0,0,1,0,1
//    each 8 clk, 4 clk low. done on cycle 76 after accept. Total 76 clk.
//  - Back-to-back 8'hFF then 8'h00, valid held -> second PRE starts the
//    cycle after done. Payload is 64 clk high, then 64 clk low.
//  - tx_valid with 8'h3C asserted mid-frame -> ignored, tx_ready=0,
//    in-flight frame bits unchanged.
//  - Reset asserted in DATA, bit 3 -> next cycle data_out=0, IDLE,
//    tx_ready=1. A new 8'h81 then sends a full fresh frame.
//  - DATA_WIDTH=1, all TICKS=1, payload 1 -> data_out 1,0,1,0 over 4 clk.
//    done on the 4th. Loopback into the detector gives exactly one out pulse
//    per frame preamble.

Source files
------------

// File: rtl/start_pulse_frame_tx_pkg.sv
// Shared definitions for the start-pulse serial link.
// Holds the 3-bit frame state encoding, the default timing constants that
// the receive side also uses, and a small helper for sizing tick counters.
package start_pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_GUARD = 3'd4
    } state_e;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_PRE_TICKS   = 4;
    localparam int DEF_START_TICKS = 4;
    localparam int DEF_BIT_TICKS   = 8;
    localparam int DEF_GUARD_TICKS = 4;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/start_pulse_frame_tx_if.sv
// Handshake and line bundle between the controller core and the frame
// transmitter.
//   tx_valid / tx_data / tx_ready : word handshake (master drives valid/data)
//   data_out                      : registered serial line toward the pad
//   busy / done                   : frame-in-progress and end-of-frame pulse
interface start_pulse_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  data_out;
    logic                  busy;
    logic                  done;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, data_out, busy, done
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, data_out, busy, done
    );
endinterface

// File: rtl/start_pulse_frame_tx_tick_timer.sv
// Loadable down-counter used to time every phase of a frame.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load_i       : load load_val_i this edge (takes priority over counting)
//   load_val_i   : phase length minus one
//   count_o      : current count
//   tc_o         : terminal count, high while the count is zero
// The counter parks at zero instead of wrapping.
module start_pulse_tick_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);
endmodule

// File: rtl/start_pulse_frame_tx.sv
// Transmit side of the start-pulse serial link.
// One accepted word becomes one frame on data_out: PRE_TICKS high, a falling
// edge into START_TICKS low, DATA_WIDTH bits MSB-first at BIT_TICKS each,
// then GUARD_TICKS low with done on the final guard cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : slave side of start_pulse_frame_tx_if
// data_out, busy and done are registered; tx_ready is combinational.
module start_pulse_frame_tx
    import start_pulse_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PRE_TICKS   = DEF_PRE_TICKS,
    parameter int START_TICKS = DEF_START_TICKS,
    parameter int BIT_TICKS   = DEF_BIT_TICKS,
    parameter int GUARD_TICKS = DEF_GUARD_TICKS
) (
    input  logic                   clock,
    input  logic                   reset,
    start_pulse_frame_tx_if.slave  bus
);
    localparam int MAX_TICKS = max4(PRE_TICKS, START_TICKS, BIT_TICKS, GUARD_TICKS);
    localparam int TICK_W    = $clog2(MAX_TICKS) + 1;
    localparam int BIT_W     = $clog2(DATA_WIDTH) + 1;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic                  data_out_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  tx_ready;
    logic                  accept;
    logic                  last_bit;
    logic                  tmr_load;
    logic [TICK_W-1:0]     tmr_load_val;
    logic [TICK_W-1:0]     tmr_count;
    logic                  tmr_tc;

    assign tx_ready = (state_q == ST_IDLE) & ~reset;
    assign accept   = bus.tx_valid & tx_ready;
    assign last_bit = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
    assign shift_d  = shift_q << 1;

    // Reload the timer with the length of whichever phase is about to begin.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                tmr_load     = accept;
                tmr_load_val = TICK_W'(PRE_TICKS - 1);
            end
            ST_PRE: begin
                tmr_load     = tmr_tc;
                tmr_load_val = TICK_W'(START_TICKS - 1);
            end
            ST_START: begin
                tmr_load     = tmr_tc;
                tmr_load_val = TICK_W'(BIT_TICKS - 1);
            end
            ST_DATA: begin
                tmr_load     = tmr_tc;
                tmr_load_val = last_bit ? TICK_W'(GUARD_TICKS - 1) : TICK_W'(BIT_TICKS - 1);
            end
            default: begin
                tmr_load     = 1'b0;
                tmr_load_val = '0;
            end
        endcase
    end

    start_pulse_tick_timer #(
        .WIDTH (TICK_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_o    (tmr_count),
        .tc_o       (tmr_tc)
    );

    // data_out is set to the level of the phase being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_PRE;
                        shift_q    <= bus.tx_data;
                        bit_cnt_q  <= '0;
                        data_out_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (tmr_tc) begin
                        state_q    <= ST_START;
                        data_out_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tmr_tc) begin
                        state_q    <= ST_DATA;
                        bit_cnt_q  <= '0;
                        data_out_q <= shift_q[DATA_WIDTH-1];
                    end
                end
                ST_DATA: begin
                    if (tmr_tc) begin
                        if (last_bit) begin
                            state_q    <= ST_GUARD;
                            bit_cnt_q  <= '0;
                            data_out_q <= 1'b0;
                            // A one-tick guard makes its first cycle the last.
                            done_q     <= (GUARD_TICKS == 1);
                        end else begin
                            shift_q    <= shift_d;
                            bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
                            data_out_q <= shift_d[DATA_WIDTH-1];
                        end
                    end
                end
                ST_GUARD: begin
                    if (tmr_tc) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tmr_count == TICK_W'(1)) begin
                        // Registered, so raise it one cycle ahead of the final tick.
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    bit_cnt_q  <= '0;
                    data_out_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_start_pulse_frame_tx.sv
module tb_start_pulse_frame_tx;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    start_pulse_frame_tx_if #(.DATA_WIDTH(8)) bus_a ();
    start_pulse_frame_tx_if #(.DATA_WIDTH(1)) bus_b ();

    start_pulse_frame_tx #(
        .DATA_WIDTH(8), .PRE_TICKS(4), .START_TICKS(4), .BIT_TICKS(8), .GUARD_TICKS(4)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    start_pulse_frame_tx #(
        .DATA_WIDTH(1), .PRE_TICKS(1), .START_TICKS(1), .BIT_TICKS(1), .GUARD_TICKS(1)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hand-derived line level for cycle n (1-based) after accept, default timing.
    function automatic logic exp_line(input int n, input logic [7:0] d);
        if (n <= 4)  return 1'b1;
        if (n <= 8)  return 1'b0;
        if (n <= 72) return d[7 - ((n - 9) / 8)];
        return 1'b0;
    endfunction

    task automatic accept_a(input logic [7:0] d);
        bus_a.tx_valid = 1'b1;
        bus_a.tx_data  = d;
        tick();
        bus_a.tx_valid = 1'b0;
    endtask

    // Called at cycle 1 after the accept edge; ends on cycle last_n.
    task automatic check_frame(input string tag, input logic [7:0] d,
                               input int ign_at, input int last_n);
        for (int n = 1; n <= last_n; n++) begin
            if (n == ign_at) begin
                bus_a.tx_valid = 1'b1;
                bus_a.tx_data  = 8'h3C;
            end
            if (n == ign_at + 10) bus_a.tx_valid = 1'b0;
            chk($sformatf("%s_line_c%0d", tag, n), 32'(bus_a.data_out), 32'(exp_line(n, d)));
            chk($sformatf("%s_done_c%0d", tag, n), 32'(bus_a.done), 32'(n == 76));
            chk($sformatf("%s_busy_c%0d", tag, n), 32'(bus_a.busy), 32'd1);
            chk($sformatf("%s_ready_c%0d", tag, n), 32'(bus_a.tx_ready), 32'd0);
            if (n < last_n) tick();
        end
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_ready"}, 32'(bus_a.tx_ready), 32'd1);
        chk({tag, "_busy"},  32'(bus_a.busy),     32'd0);
        chk({tag, "_done"},  32'(bus_a.done),     32'd0);
        chk({tag, "_line"},  32'(bus_a.data_out), 32'd0);
    endtask

    logic exp_b_line [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_b_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset          = 1'b1;
        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = 8'h00;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = 1'b0;

        // Reset
        repeat (3) tick();
        chk("rst_line",  32'(bus_a.data_out), 32'd0);
        chk("rst_busy",  32'(bus_a.busy),     32'd0);
        chk("rst_done",  32'(bus_a.done),     32'd0);
        chk("rst_ready_held", 32'(bus_a.tx_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready_a", 32'(bus_a.tx_ready), 32'd1);
        chk("rst_ready_b", 32'(bus_b.tx_ready), 32'd1);

        // Single frame A5
        accept_a(8'hA5);
        check_frame("a5", 8'hA5, -100, 76);
        tick();
        check_idle_a("a5_after");

        // Back-to-back FF then 00 with valid held
        bus_a.tx_valid = 1'b1;
        bus_a.tx_data  = 8'hFF;
        tick();
        bus_a.tx_data  = 8'h00;
        check_frame("ff", 8'hFF, -100, 76);
        tick();
        chk("b2b_gap_ready", 32'(bus_a.tx_ready), 32'd1);
        chk("b2b_gap_line",  32'(bus_a.data_out), 32'd0);
        tick();
        bus_a.tx_valid = 1'b0;
        check_frame("00", 8'h00, -100, 76);
        tick();
        check_idle_a("b2b_after");

        // tx_valid with 3C mid-frame is ignored
        accept_a(8'hA5);
        check_frame("ign", 8'hA5, 20, 76);
        tick();
        check_idle_a("ign_after");

        // Reset during DATA bit 3, then a fresh 81 frame
        accept_a(8'hA5);
        check_frame("prerst", 8'hA5, -100, 35);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_idle_a("midrst");
        tick();
        chk("midrst_stay_line", 32'(bus_a.data_out), 32'd0);
        chk("midrst_stay_busy", 32'(bus_a.busy),     32'd0);
        accept_a(8'h81);
        check_frame("81", 8'h81, -100, 76);
        tick();
        check_idle_a("81_after");

        // Minimal configuration: one bit, all ticks 1, payload 1
        bus_b.tx_valid = 1'b1;
        bus_b.tx_data  = 1'b1;
        tick();
        bus_b.tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("min_line_c%0d", i + 1), 32'(bus_b.data_out), 32'(exp_b_line[i]));
            chk($sformatf("min_done_c%0d", i + 1), 32'(bus_b.done),     32'(exp_b_done[i]));
            chk($sformatf("min_busy_c%0d", i + 1), 32'(bus_b.busy),     32'd1);
            if (i < 3) tick();
        end
        tick();
        chk("min_after_ready", 32'(bus_b.tx_ready), 32'd1);
        chk("min_after_busy",  32'(bus_b.busy),     32'd0);
        chk("min_after_done",  32'(bus_b.done),     32'd0);
        chk("min_after_line",  32'(bus_b.data_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
